// File: rtl/bonus_pkg.sv
// Shared types and helpers for the bonus scheduler.
//   bonus_t        : the four bonus kinds, encoded as the 2-bit slot/effect type
//   sched_state_t  : spawn FSM states
//   COORD_W        : width of screen coordinates
//   lfsr_next()    : one step of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
package bonus_pkg;

  localparam int COORD_W = 11;

  typedef enum logic [1:0] {B_WIDE, B_SLOW, B_LIFE, B_MULTI} bonus_t;

  typedef enum logic {S_IDLE, S_ARM} sched_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

endpackage

// File: rtl/bonus_effect_timer.sv
// Frame-count timer for one bonus effect type.
//   clk_i          : system clock
//   reset_i        : synchronous active-high reset
//   clear_i        : drop the effect immediately (level switch)
//   load_i         : catch of this type; (re)loads EFFECT_FRAMES
//   startOfFrame_i : frame tick, decrements a running count
//   active_o       : effect running (count nonzero)
module bonus_effect_timer #(
  parameter int EFFECT_FRAMES = 300
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic load_i,
  input  logic startOfFrame_i,
  output logic active_o
);

  localparam int CW = (EFFECT_FRAMES < 1) ? 1 : $clog2(EFFECT_FRAMES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Load beats a same-clock decrement so a retrigger always gets the full time.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)                            cnt_d = '0;
    else if (load_i)                        cnt_d = CW'(EFFECT_FRAMES);
    else if (startOfFrame_i && cnt_q != '0) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign active_o = (cnt_q != '0);

endmodule

// File: rtl/bonus_scheduler.sv
// Shares N_SLOTS falling-bonus movers between brick-hit spawn requests and
// runs per-type effect timers when a bonus is caught.
//   clk_i, reset_i      : clock, synchronous active-high reset
//   startOfFrame_i      : 1-clk frame tick
//   lvl_i               : current level; any change clears scheduler state
//   brickHit_i/X/Y      : brick destroyed at (X,Y)
//   activeFlags_i       : per-slot mover busy flag
//   bonusCollision_i    : per-slot paddle collision
//   activate_o          : one-hot arm request to the chosen mover
//   topXStart_o/Y       : start position, stable while activate_o is set
//   slotType_o          : 2-bit type per slot
//   effectStart_o/Type  : 1-clk catch pulse and caught type
//   effectActive_o      : per-type effect running
//   dropCount_o         : saturating count of lost hits
module bonus_scheduler
  import bonus_pkg::*;
#(
  parameter int          N_SLOTS         = 3,
  parameter int          N_TYPES         = 4,
  parameter int          SPAWN_CHANCE    = 3,
  parameter int          COOLDOWN_FRAMES = 30,
  parameter int          EFFECT_FRAMES   = 300,
  parameter int          ARM_TIMEOUT     = 4,
  parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 startOfFrame_i,
  input  logic [1:0]           lvl_i,
  input  logic                 brickHit_i,
  input  logic [COORD_W-1:0]   brickX_i,
  input  logic [COORD_W-1:0]   brickY_i,
  input  logic [N_SLOTS-1:0]   activeFlags_i,
  input  logic [N_SLOTS-1:0]   bonusCollision_i,
  output logic [N_SLOTS-1:0]   activate_o,
  output logic [COORD_W-1:0]   topXStart_o,
  output logic [COORD_W-1:0]   topYStart_o,
  output logic [2*N_SLOTS-1:0] slotType_o,
  output logic                 effectStart_o,
  output logic [1:0]           effectType_o,
  output logic [N_TYPES-1:0]   effectActive_o,
  output logic [7:0]           dropCount_o
);

  localparam int CDW = (COOLDOWN_FRAMES < 1) ? 1 : $clog2(COOLDOWN_FRAMES + 1);
  localparam int ACW = (ARM_TIMEOUT < 1) ? 1 : $clog2(ARM_TIMEOUT + 1);

  sched_state_t                    state_q, state_d;
  logic [15:0]                     lfsr_q, lfsr_d;
  logic [1:0]                      lvl_q;
  logic                            pend_vld_q, pend_vld_d;
  logic [COORD_W-1:0]              pend_x_q, pend_x_d, pend_y_q, pend_y_d;
  logic [CDW-1:0]                  cool_q, cool_d;
  logic [ACW-1:0]                  arm_cnt_q, arm_cnt_d;
  logic [COORD_W-1:0]              x_q, x_d, y_q, y_d;
  bonus_t                          type_q, type_d;
  logic [N_SLOTS-1:0]              act_q, act_d;
  logic [N_SLOTS-1:0][1:0]         slot_type_q, slot_type_d;
  logic                            eff_start_q, eff_start_d;
  logic [1:0]                      eff_type_q, eff_type_d;
  logic [7:0]                      drop_q, drop_d;

  logic                            lvl_sw, chance_ok, free_found, catch_any;
  logic [N_SLOTS-1:0]              free_oh, catch_vec;
  logic [1:0]                      catch_type, drop_add;
  logic [N_TYPES-1:0]              eff_load;
  logic [8:0]                      drop_sum;

  assign lvl_sw    = (lvl_i != lvl_q);
  assign chance_ok = ({1'b0, lfsr_q[2:0]} < 4'(SPAWN_CHANCE));
  assign catch_vec = bonusCollision_i & activeFlags_i;
  assign catch_any = |catch_vec;

  // Lowest free slot and lowest catching slot (descending loops, last write wins).
  always_comb begin
    free_oh    = '0;
    free_found = 1'b0;
    catch_type = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!activeFlags_i[i]) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
        free_found = 1'b1;
      end
      if (catch_vec[i]) catch_type = slot_type_q[i];
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_next(lfsr_q);
    pend_vld_d  = pend_vld_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    cool_d      = cool_q;
    arm_cnt_d   = arm_cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    type_d      = type_q;
    act_d       = act_q;
    slot_type_d = slot_type_q;
    eff_start_d = 1'b0;
    eff_type_d  = eff_type_q;
    eff_load    = '0;
    drop_add    = '0;

    if (lvl_sw) begin
      // Level switch overrides everything; same-clock hits and catches vanish.
      state_d    = S_IDLE;
      act_d      = '0;
      pend_vld_d = 1'b0;
      cool_d     = '0;
    end else begin
      if (startOfFrame_i && cool_q != '0) cool_d = cool_q - 1'b1;

      if (catch_any) begin
        eff_start_d          = 1'b1;
        eff_type_d           = catch_type;
        eff_load[catch_type] = 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          // A waiting pending entry is served first; it stays parked until the
          // cooldown has expired.
          if ((pend_vld_q || brickHit_i) && cool_q == '0) begin
            if (pend_vld_q) begin
              pend_vld_d = brickHit_i;
              pend_x_d   = brickX_i;
              pend_y_d   = brickY_i;
            end
            if (chance_ok) begin
              if (free_found) begin
                x_d       = pend_vld_q ? pend_x_q : brickX_i;
                y_d       = pend_vld_q ? pend_y_q : brickY_i;
                type_d    = bonus_t'(2'(int'(lfsr_q[5:4]) % N_TYPES));
                act_d     = free_oh;
                arm_cnt_d = '0;
                state_d   = S_ARM;
              end else begin
                drop_add = drop_add + 2'd1;
              end
            end
          end
        end
        S_ARM: begin
          arm_cnt_d = arm_cnt_q + 1'b1;
          if (|(activeFlags_i & act_q)) begin
            for (int i = 0; i < N_SLOTS; i++)
              if (act_q[i]) slot_type_d[i] = type_q;
            cool_d  = CDW'(COOLDOWN_FRAMES);
            act_d   = '0;
            state_d = S_IDLE;
          end else if (arm_cnt_q == ACW'(ARM_TIMEOUT - 1)) begin
            act_d    = '0;
            state_d  = S_IDLE;
            drop_add = drop_add + 2'd1;
          end
          if (brickHit_i) begin
            if (!pend_vld_q) begin
              pend_vld_d = 1'b1;
              pend_x_d   = brickX_i;
              pend_y_d   = brickY_i;
            end else begin
              drop_add = drop_add + 2'd1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    drop_sum = {1'b0, drop_q} + {7'd0, drop_add};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_SEED;
      lvl_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      cool_q      <= '0;
      arm_cnt_q   <= '0;
      x_q         <= '0;
      y_q         <= '0;
      type_q      <= B_WIDE;
      act_q       <= '0;
      slot_type_q <= '0;
      eff_start_q <= 1'b0;
      eff_type_q  <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      lvl_q       <= lvl_i;
      pend_vld_q  <= pend_vld_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      cool_q      <= cool_d;
      arm_cnt_q   <= arm_cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      type_q      <= type_d;
      act_q       <= act_d;
      slot_type_q <= slot_type_d;
      eff_start_q <= eff_start_d;
      eff_type_q  <= eff_type_d;
      drop_q      <= drop_d;
    end
  end

  for (genvar t = 0; t < N_TYPES; t++) begin : g_eff
    bonus_effect_timer #(.EFFECT_FRAMES(EFFECT_FRAMES)) u_timer (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .clear_i        (lvl_sw),
      .load_i         (eff_load[t]),
      .startOfFrame_i (startOfFrame_i),
      .active_o       (effectActive_o[t])
    );
  end

  assign activate_o    = act_q;
  assign topXStart_o   = x_q;
  assign topYStart_o   = y_q;
  assign slotType_o    = slot_type_q;
  assign effectStart_o = eff_start_q;
  assign effectType_o  = eff_type_q;
  assign dropCount_o   = drop_q;

endmodule
